single_port_ram_arbiter: RTL

Two-requester round-robin arbiter that shares one 64x8 single-port RAM (`single_port_ram`) between requesters A and B. It grants at most one access per cycle and drives the RAM `we`/`addr`/`data` pins from the winner. It returns read data to the correct requester one cycle later. It also supports a bounded lock (burst) so one requester can hold the RAM for consecutive accesses without starving the other.

---
 rtl/spram_pkg.sv | 17 +
 rtl/single_port_ram.sv | 24 ++
 rtl/single_port_ram_arbiter_rr_pick2.sv | 31 +++
 rtl/single_port_ram_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM and its two-requester arbiter:
// FSM states, requester ids and default RAM geometry.
package spram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int SPRAM_AW = 6;
  localparam int SPRAM_DW = 8;

endpackage

// File: rtl/single_port_ram.sv
// 2**AW x DW single-port RAM; synchronous write, registered read of the
// address sampled at the rising edge.
module single_port_ram
  import spram_pkg::*;
#(
  parameter int AW = SPRAM_AW,
  parameter int DW = SPRAM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] val
);

  logic [DW-1:0] mem [2**AW];

  // Write lands before the read of the following cycle, so RAW returns new data.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    val <= mem[addr];
  end

endmodule

// File: rtl/single_port_ram_arbiter_rr_pick2.sv
// Combinational 2-way pick: sole requester wins; on a tie the locked owner
// keeps the RAM until its burst is exhausted, otherwise the other side wins.
module rr_pick2
  import spram_pkg::*;
(
  input  logic [1:0] req_i,        // bit 0 = A, bit 1 = B
  input  state_e     owner_i,
  input  logic       lock_i,
  input  logic       burst_done_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  logic hold;

  always_comb begin
    gnt_o = 2'b00;
    hold  = lock_i && !burst_done_i;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (owner_i == ST_OWN_A)      gnt_o = hold ? 2'b01 : 2'b10;
        else if (owner_i == ST_OWN_B) gnt_o = hold ? 2'b10 : 2'b01;
        else                          gnt_o = (last_gnt_i == ID_B) ? 2'b01 : 2'b10;
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// with bounded lock bursts and a one-cycle read return to the winner.
module single_port_ram_arbiter
  import spram_pkg::*;
#(
  parameter int AW        = SPRAM_AW,
  parameter int DW        = SPRAM_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          lock_q, lock_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          a_rvalid_q, b_rvalid_q;
  logic [1:0]    pick;
  logic          burst_done;
  logic          xfer_a, xfer_b;
  logic [BW-1:0] burst_inc;

  assign burst_done = (burst_cnt_q >= BW'(MAX_BURST));
  assign burst_inc  = burst_done ? burst_cnt_q : burst_cnt_q + BW'(1);

  rr_pick2 u_pick (
    .req_i        ({b_req, a_req}),
    .owner_i      (state_q),
    .lock_i       (lock_q),
    .burst_done_i (burst_done),
    .last_gnt_i   (last_gnt_q),
    .gnt_o        (pick)
  );

  // Grants are suppressed for as long as reset is held.
  assign a_gnt  = pick[0] & rst_n;
  assign b_gnt  = pick[1] & rst_n;
  assign xfer_a = a_req & a_gnt;
  assign xfer_b = b_req & b_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_comb begin
    state_d     = ST_IDLE;
    burst_cnt_d = '0;
    lock_d      = 1'b0;
    last_gnt_d  = last_gnt_q;
    if (xfer_a) begin
      state_d     = ST_OWN_A;
      lock_d      = a_lock;
      last_gnt_d  = ID_A;
      burst_cnt_d = (state_q == ST_OWN_A) ? burst_inc : BW'(1);
    end else if (xfer_b) begin
      state_d     = ST_OWN_B;
      lock_d      = b_lock;
      last_gnt_d  = ID_B;
      burst_cnt_d = (state_q == ST_OWN_B) ? burst_inc : BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= ID_B;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
      a_rvalid_q  <= xfer_a & ~a_we;
      b_rvalid_q  <= xfer_b & ~b_we;
    end
  end

  // Read return stage: RAM data steered to whichever side issued the read.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? ram_rdata : '0;
  assign b_rdata  = b_rvalid_q ? ram_rdata : '0;

endmodule
